// File: rtl/tomasula_types.sv
// rtl/tomasula_types.sv - shared types for the Tomasulo reorder buffer
// Contents: op_t instruction class, rob_entry_t per-entry state,
// rob_cstate_e commit FSM states, is_load/is_store helpers.
package tomasula_types;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_LW     = 3'd2,
    OP_LH     = 3'd3,
    OP_LB     = 3'd4,
    OP_SW     = 3'd5,
    OP_SH     = 3'd6,
    OP_SB     = 3'd7
  } op_t;

  // rd holds the store data source register for stores
  typedef struct packed {
    op_t        op;
    logic [4:0] rd;
    logic       pred;
    logic       alloc;
    logic       done;
  } rob_entry_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_MEM  = 1'b1
  } rob_cstate_e;

  function automatic logic is_load(input op_t op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/rob_wmask_gen.sv
// rtl/rob_wmask_gen.sv - byte write mask for the store at the ROB head
// Ports: i_op (instruction class), i_offset (addr[1:0]), o_wmask (byte enables).
// SW -> 1111, SH -> 0011<<off, SB -> 0001<<off, anything else -> 0000.
module rob_wmask_gen
  import tomasula_types::*;
(
  input  op_t        i_op,
  input  logic [1:0] i_offset,
  output logic [3:0] o_wmask
);

  always_comb begin
    o_wmask = 4'b0000;
    case (i_op)
      OP_SW:   o_wmask = 4'b1111;
      OP_SH:   o_wmask = 4'b0011 << i_offset;
      OP_SB:   o_wmask = 4'b0001 << i_offset;
      default: o_wmask = 4'b0000;
    endcase
  end

endmodule

// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised in-order-commit reorder buffer
// Ports: alloc_* (program-order allocation, tag on alloc_idx), wb_set (done strobes),
// br_* (branch resolution; mispredict raises flush/ld_pc/flush_idx),
// mem_* / wmask (head load/store handshake), regfile_load / ld_commit_sel / commit_rd
// (commit), head_idx, entry_alloc / entry_done (per-entry status).
// Optional: ROB_PERF_CNT_EN adds saturating perf_commits / perf_flushes counters.
module rob_param
  import tomasula_types::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  op_t              alloc_op,
  input  logic [4:0]       alloc_rd,
  input  logic [4:0]       alloc_st_src,
  input  logic             alloc_pred,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0] wb_set,
  input  logic             br_update,
  input  logic [IDX_W-1:0] br_idx,
  input  logic             br_taken,
  input  logic [1:0]       mem_offset,
  input  logic             mem_resp,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       wmask,
  output logic             regfile_load,
  output logic             ld_commit_sel,
  output logic [4:0]       commit_rd,
  output logic [IDX_W-1:0] head_idx,
  output logic             flush,
  output logic             ld_pc,
  output logic [IDX_W-1:0] flush_idx,
  output logic [DEPTH-1:0] entry_alloc,
  output logic [DEPTH-1:0] entry_done
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]      perf_commits,
  output logic [31:0]      perf_flushes
`endif
);

  localparam int CNT_W = IDX_W + 1;

  rob_entry_t       r_ent [DEPTH];
  logic [IDX_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  rob_cstate_e      r_cstate;
  logic             r_mem_read, r_mem_write;

  logic             w_head_rdy, w_full, w_pop, w_pop_alu, w_mem_done;
  logic             w_br_ok, w_mispred, w_alloc;
  logic [IDX_W-1:0] w_br_off;
  logic [DEPTH-1:0] w_squash;
  logic [3:0]       w_wmask;

  assign w_head_rdy = r_ent[r_head].alloc && r_ent[r_head].done;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop_alu  = (r_cstate == C_IDLE) && w_head_rdy && (r_ent[r_head].op == OP_ALU);
  assign w_mem_done = (r_cstate == C_MEM) && mem_resp;
  assign w_pop      = w_pop_alu || w_mem_done ||
                      ((r_cstate == C_IDLE) && w_head_rdy && (r_ent[r_head].op == OP_BRANCH));

  assign w_br_ok   = br_update && r_ent[br_idx].alloc && (r_ent[br_idx].op == OP_BRANCH);
  assign w_mispred = w_br_ok && (br_taken != r_ent[br_idx].pred);
  assign w_br_off  = br_idx - r_head;

  // Squash by age relative to head so the test is wrap-safe
  always_comb begin
    w_squash = '0;
    for (int i = 0; i < DEPTH; i++)
      w_squash[i] = w_mispred && ((IDX_W'(i) - r_head) > w_br_off);
  end

  // A commit in the same cycle frees the head slot, so a full ROB can still accept
  assign alloc_ready   = (!w_full || w_pop) && !w_mispred;
  assign w_alloc       = alloc_valid && alloc_ready;
  assign alloc_idx     = r_tail;
  assign head_idx      = r_head;
  assign flush         = w_mispred;
  assign ld_pc         = w_mispred;
  assign flush_idx     = w_mispred ? br_idx : '0;
  assign regfile_load  = w_pop_alu || (w_mem_done && is_load(r_ent[r_head].op));
  assign ld_commit_sel = w_mem_done && is_load(r_ent[r_head].op);
  assign commit_rd     = r_ent[r_head].rd;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign wmask         = r_mem_write ? w_wmask : 4'b0000;

  always_comb begin
    entry_alloc = '0;
    entry_done  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_alloc[i] = r_ent[i].alloc;
      entry_done[i]  = r_ent[i].done;
    end
  end

  rob_wmask_gen u_wmask (
    .i_op     (r_ent[r_head].op),
    .i_offset (mem_offset),
    .o_wmask  (w_wmask)
  );

  // Entry state; later assignments take priority (squash/commit over writeback)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_set[i] && r_ent[i].alloc) r_ent[i].done <= 1'b1;
        if (w_squash[i])                 r_ent[i]      <= '0;
      end
      if (w_br_ok) r_ent[br_idx].done <= 1'b1;
      if (w_pop)   r_ent[r_head]      <= '0;
      if (w_alloc)
        r_ent[r_tail] <= '{op:    alloc_op,
                           rd:    is_store(alloc_op) ? alloc_st_src : alloc_rd,
                           pred:  alloc_pred && (alloc_op == OP_BRANCH),
                           alloc: 1'b1,
                           done:  1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_mispred) begin
        // Branch stays; entries head..br_idx survive, minus any commit this cycle
        r_tail  <= br_idx + 1'b1;
        r_count <= CNT_W'(w_br_off) + CNT_W'(1) - CNT_W'(w_pop);
      end else begin
        if (w_alloc) r_tail <= r_tail + 1'b1;
        r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
      end
    end
  end

  // Commit FSM: memory ops at the head hold their request until mem_resp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cstate    <= C_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_cstate)
        C_IDLE: begin
          if (w_head_rdy && (is_load(r_ent[r_head].op) || is_store(r_ent[r_head].op))) begin
            r_cstate    <= C_MEM;
            r_mem_read  <= is_load(r_ent[r_head].op);
            r_mem_write <= is_store(r_ent[r_head].op);
          end
        end
        C_MEM: begin
          if (mem_resp) begin
            r_cstate    <= C_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: r_cstate <= C_IDLE;
      endcase
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commits, r_perf_flushes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_commits <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_pop && (r_perf_commits != '1))     r_perf_commits <= r_perf_commits + 1'b1;
      if (w_mispred && (r_perf_flushes != '1)) r_perf_flushes <= r_perf_flushes + 1'b1;
    end
  end

  assign perf_commits = r_perf_commits;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - scoreboard bench for rob_param
module tb_rob_param;
  import tomasula_types::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_valid = 1'b0;
  op_t              alloc_op = OP_ALU;
  logic [4:0]       alloc_rd = '0, alloc_st_src = '0;
  logic             alloc_pred = 1'b0;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic [DEPTH-1:0] wb_set = '0;
  logic             br_update = 1'b0;
  logic [IDX_W-1:0] br_idx = '0;
  logic             br_taken = 1'b0;
  logic [1:0]       mem_offset = '0;
  logic             mem_resp = 1'b0;
  logic             mem_read, mem_write;
  logic [3:0]       wmask;
  logic             regfile_load, ld_commit_sel;
  logic [4:0]       commit_rd;
  logic [IDX_W-1:0] head_idx, flush_idx;
  logic             flush, ld_pc;
  logic [DEPTH-1:0] entry_alloc, entry_done;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]      perf_commits, perf_flushes;
`endif

  always #5 clk = ~clk;

  rob_param #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_rd(alloc_rd),
    .alloc_st_src(alloc_st_src), .alloc_pred(alloc_pred),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_set(wb_set),
    .br_update(br_update), .br_idx(br_idx), .br_taken(br_taken),
    .mem_offset(mem_offset), .mem_resp(mem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .wmask(wmask),
    .regfile_load(regfile_load), .ld_commit_sel(ld_commit_sel), .commit_rd(commit_rd),
    .head_idx(head_idx), .flush(flush), .ld_pc(ld_pc), .flush_idx(flush_idx),
    .entry_alloc(entry_alloc), .entry_done(entry_done)
`ifdef ROB_PERF_CNT_EN
    , .perf_commits(perf_commits), .perf_flushes(perf_flushes)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0] rd;
    logic       ld;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   cyc = 0, n_rf = 0, first_rf = 0, last_rf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every regfile write must match the oldest outstanding writer
  always @(negedge clk) begin
    if (!rst && regfile_load) begin
      if (n_rf == 0) first_rf = cyc;
      n_rf++;
      last_rf = cyc;
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        m_e = sb.pop_front();
        check("commit_rd", commit_rd, m_e.rd);
        check("ld_sel", ld_commit_sel, m_e.ld);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    alloc_valid = 1'b0; wb_set = '0; br_update = 1'b0; mem_resp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic do_alloc(input op_t op, input logic [4:0] rd, input logic pred,
                          output logic acc, output logic [IDX_W-1:0] tag);
    alloc_valid  = 1'b1;
    alloc_op     = op;
    alloc_st_src = rd;
    alloc_rd     = is_store(op) ? ~rd : rd;
    alloc_pred   = pred;
    @(negedge clk);
    acc = alloc_ready;
    tag = alloc_idx;
    if (acc && (op == OP_ALU || is_load(op))) sb.push_back('{rd, is_load(op)});
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (entry_alloc == '0) break;
    end
    check(tag, entry_alloc, 0);
    tick();
  endtask

  op_t        st_ops  [3] = '{OP_SH, OP_SW, OP_SB};
  logic [1:0] st_offs [3] = '{2'd2, 2'd1, 2'd3};
  logic [3:0] st_mask [3] = '{4'b1100, 4'b1111, 4'b1000};
  op_t        t5_ops  [6] = '{OP_ALU, OP_ALU, OP_BRANCH, OP_ALU, OP_ALU, OP_ALU};

  initial begin
    logic acc;
    logic [IDX_W-1:0] tag;
    int k;

    do_reset();
    @(negedge clk);
    check("rst_ready", alloc_ready, 1);
    check("rst_alloc_idx", alloc_idx, 0);
    check("rst_head", head_idx, 0);
    check("rst_entries", {entry_alloc, entry_done}, 0);
    check("rst_mem", {mem_read, mem_write, wmask}, 0);
    check("rst_flush", {flush, ld_pc, flush_idx}, 0);
    check("rst_rf", {regfile_load, ld_commit_sel}, 0);
    tick();

    // 1: fill with no commits
    for (int i = 0; i < 8; i++) begin
      do_alloc(OP_ALU, 5'(i + 1), 1'b0, acc, tag);
      check("t1_acc", acc, 1);
      check("t1_tag", tag, i);
    end
    @(negedge clk);
    check("t1_ready", alloc_ready, 0);
    check("t1_idx_wrap", alloc_idx, 0);
    check("t1_full", entry_alloc, 8'hFF);
    tick();
    do_alloc(OP_ALU, 5'd31, 1'b0, acc, tag);
    check("t1_reject", acc, 0);

    // 2: all done at once -> eight back-to-back commits
    n_rf = 0;
    wb_set = 8'hFF;
    tick();
    wb_set = '0;
    for (k = 0; k < 20 && n_rf < 8; k++) @(posedge clk);
    #1;
    check("t2_pulses", n_rf, 8);
    check("t2_consec", last_rf - first_rf, 7);
    @(negedge clk);
    check("t2_empty", entry_alloc, 0);
    check("t2_ready", alloc_ready, 1);
    check("t2_sb", sb.size(), 0);
    tick();

    // 3: load at head, response on third request cycle
    do_alloc(OP_LW, 5'd9, 1'b0, acc, tag);
    wb_set = DEPTH'(1) << tag;
    tick();
    wb_set = '0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_read) break;
    end
    check("t3_rd_up", mem_read, 1);
    check("t3_no_wr", mem_write, 0);
    n_rf = 0;
    for (int c = 2; c <= 3; c++) begin
      tick();
      mem_resp = (c == 3);
      @(negedge clk);
      check("t3_rd_held", mem_read, 1);
      check("t3_rf", regfile_load, (c == 3) ? 1 : 0);
    end
    check("t3_sel", ld_commit_sel, 1);
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    check("t3_rd_drop", mem_read, 0);
    check("t3_one_rf", n_rf, 1);
    check("t3_empty", entry_alloc, 0);
    tick();

    // 4: stores of each width
    for (int j = 0; j < 3; j++) begin
      mem_offset = st_offs[j];
      do_alloc(st_ops[j], 5'(12 + j), 1'b0, acc, tag);
      wb_set = DEPTH'(1) << tag;
      tick();
      wb_set = '0;
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (mem_write) break;
      end
      check("t4_wr_up", mem_write, 1);
      check("t4_no_rd", mem_read, 0);
      check("t4_wmask", wmask, st_mask[j]);
      check("t4_src", commit_rd, 12 + j);
      tick();
      @(negedge clk);
      check("t4_held", mem_write, 1);
      check("t4_not_popped", entry_alloc != 0, 1);
      tick();
      mem_resp = 1'b1;
      @(negedge clk);
      check("t4_no_rf", regfile_load, 0);
      tick();
      mem_resp = 1'b0;
      @(negedge clk);
      check("t4_wr_drop", mem_write, 0);
      check("t4_empty", entry_alloc, 0);
      tick();
    end

    // async reset drops a pending load request immediately
    do_alloc(OP_LB, 5'd7, 1'b0, acc, tag);
    wb_set = DEPTH'(1) << tag;
    tick();
    wb_set = '0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_read) break;
    end
    check("rm_rd_up", mem_read, 1);
    rst = 1'b1;
    #1;
    check("rm_async_drop", mem_read, 0);
    do_reset();

    // 5: mispredicted branch squashes younger entries
    for (int i = 0; i < 6; i++) begin
      do_alloc(t5_ops[i], 5'(i + 1), 1'b0, acc, tag);
      check("t5_acc", acc, 1);
    end
    br_update = 1'b1; br_idx = 3'd0; br_taken = 1'b1;
    @(negedge clk);
    check("t5_nonbr_ignored", flush, 0);
    tick();
    br_idx = 3'd2; br_taken = 1'b0;
    @(negedge clk);
    check("t5_predicted_ok", flush, 0);
    tick();
    br_taken = 1'b1;
    alloc_valid = 1'b1; alloc_op = OP_ALU; alloc_rd = 5'd30;
    @(negedge clk);
    check("t5_flush", {flush, ld_pc}, 2'b11);
    check("t5_flush_idx", flush_idx, 2);
    check("t5_ready_low", alloc_ready, 0);
    tick();
    br_update = 1'b0; alloc_valid = 1'b0;
    repeat (3) void'(sb.pop_back());
    @(negedge clk);
    check("t5_flush_gone", flush, 0);
    check("t5_alloc", entry_alloc, 8'h07);
    check("t5_done", entry_done, 8'h04);
    check("t5_tail", alloc_idx, 3);
    check("t5_ready", alloc_ready, 1);
    tick();
    wb_set = 8'h03;
    tick();
    wb_set = '0;
    wait_empty("t5_drain");
    check("t5_sb", sb.size(), 0);

    // 6: alloc into a full ROB while the head commits
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(OP_ALU, 5'(i + 1), 1'b0, acc, tag);
    wb_set = 8'h01;
    tick();
    wb_set = '0;
    do_alloc(OP_ALU, 5'd20, 1'b0, acc, tag);
    check("t6_acc", acc, 1);
    check("t6_tag", tag, 0);
    @(negedge clk);
    check("t6_full", entry_alloc, 8'hFF);
    check("t6_tail", alloc_idx, 1);
    check("t6_head", head_idx, 1);
    check("t6_ready", alloc_ready, 0);
    tick();
    n_rf = 0;
    wb_set = 8'hFF;
    tick();
    wb_set = '0;
    wait_empty("t6_drain");
    check("t6_rf", n_rf, 8);
    check("t6_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
